// File: rtl/reg_dump_reader.sv
// Debug register dump: walks x0..x(NUM_REGS-1) over the register file debug read
// port and streams a header byte followed by each register MSB-first on a valid/ready byte link.
module reg_dump_reader #(
    parameter int          NUM_REGS = 32,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic [4:0]  dbg_reg_ra,
    input  logic [31:0] dbg_reg_rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_idx;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_shreg;
    logic        w_last_byte;

    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign dbg_reg_ra  = r_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode from state only, so tx_valid never depends on tx_ready.
    always_comb begin
        w_next   = r_state;
        tx_valid = 1'b0;
        tx_data  = '0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_HEADER;
                end
            end
            S_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = r_shreg[31:24];
                if (tx_ready && w_last_byte) begin
                    w_next = (r_idx == LAST_IDX) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_shreg    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                    end
                end
                S_LOAD: begin
                    r_shreg    <= dbg_reg_rd;
                    r_byte_cnt <= '0;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        r_shreg    <= {r_shreg[23:0], 8'h00};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte && (r_idx != LAST_IDX)) begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected bytes are queued by the stimulus
// and popped by a negedge monitor on every transfer.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [4:0]  dbg_reg_ra;
    logic [31:0] dbg_reg_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic        start1;
    logic [4:0]  dbg_reg_ra1;
    logic [31:0] dbg_reg_rd1;
    logic [7:0]  tx_data1;
    logic        tx_valid1;
    logic        tx_ready1;
    logic        busy1;
    logic        done1;

    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          exp_done_cycle = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dbg_reg_rd  = (dbg_reg_ra == 5'd0) ? 32'h0 : regs[dbg_reg_ra];
    assign dbg_reg_rd1 = (dbg_reg_ra1 == 5'd0) ? 32'h1122_3344 : 32'h0;

    reg_dump_reader #(.NUM_REGS(32), .HEADER(8'hA5)) u_dut (
        .clk(clk), .rstn(rstn), .start(start),
        .dbg_reg_ra(dbg_reg_ra), .dbg_reg_rd(dbg_reg_rd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    reg_dump_reader #(.NUM_REGS(1), .HEADER(8'hA5)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start1),
        .dbg_reg_ra(dbg_reg_ra1), .dbg_reg_rd(dbg_reg_rd1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_reg(input int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    endfunction

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic push_frame();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 32; i++) push_word(model_reg(i));
    endtask

    // Monitor: consumes one expected byte per transfer and checks hold-while-stalled.
    always @(negedge clk) begin
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            if (done) begin
                n_done++;
                if (exp_done_cycle != 0)
                    chk("done_cycle", 32'(cyc - start_cyc + 1), 32'(exp_done_cycle));
                chk("busy_at_done", 32'(busy), 32'd1);
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    // Runs one frame; cycle c=1 is the HEADER cycle. abort_c != 0 drops reset in that cycle.
    task automatic run_frame(input bit bp, input bit snap, input bit filt,
                             input int abort_c, input int exp_done);
        int  c;
        bit  seen_done;
        int  done_before;
        done_before    = n_done;
        exp_done_cycle = exp_done;
        seen_done      = 1'b0;
        tx_ready       = 1'b1;
        start          = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        for (int n = 0; n < 3000; n++) begin
            c = cyc - start_cyc + 1;
            if (c == 1) chk("busy_c1", 32'(busy), 32'd1);
            if (bp) tx_ready = ($urandom_range(0, 9) < 3);
            if (snap && c == 28) regs[5] = 32'hDEAD_BEEF;
            if (filt) start = (c == 10 || c == 162);
            if (abort_c != 0 && c == abort_c) begin
                rstn = 1'b0;
                #1;
                chk("abort_valid", 32'(tx_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_ra", 32'(dbg_reg_ra), 32'd0);
                @(posedge clk); #1;
                chk("abort_no_done", 32'(n_done), 32'(done_before));
                chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
                rstn = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                chk("abort_idle_valid", 32'(tx_valid), 32'd0);
                return;
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("done_seen", 32'(seen_done), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("frame_q_empty", 32'(exp_q.size()), 32'd0);
        chk("one_done", 32'(n_done - done_before), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        tx_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] d1 [1:6];
        d1[1] = 8'hA5; d1[2] = 8'h00; d1[3] = 8'h11;
        d1[4] = 8'h22; d1[5] = 8'h33; d1[6] = 8'h44;
        for (int i = 0; i < 32; i++) regs[i] = model_reg(i);
        rstn = 1'b0; start = 1'b0; start1 = 1'b0;
        tx_ready = 1'b0; tx_ready1 = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start    = 1'($urandom_range(0, 1));
            tx_ready = 1'($urandom_range(0, 1));
            start1   = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_out", {tx_data, dbg_reg_ra, tx_valid, busy, done}, 32'd0);
            chk("rst_out1", {tx_data1, dbg_reg_ra1, tx_valid1, busy1, done1}, 32'd0);
        end
        @(posedge clk); #1;
        start = 1'b0; start1 = 1'b0; tx_ready = 1'b1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        push_frame();
        run_frame(1'b0, 1'b0, 1'b0, 0, 162);

        push_frame();
        run_frame(1'b1, 1'b0, 1'b0, 0, 0);

        push_frame();
        run_frame(1'b0, 1'b1, 1'b0, 0, 162);
        regs[5] = model_reg(5);

        push_frame();
        run_frame(1'b0, 1'b0, 1'b1, 0, 162);

        exp_q.push_back(8'hA5);
        for (int i = 0; i < 7; i++) push_word(model_reg(i));
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h00);
        run_frame(1'b0, 1'b0, 1'b0, 40, 0);

        push_frame();
        run_frame(1'b0, 1'b0, 1'b0, 0, 162);

        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 6) begin
                chk("n1_valid", 32'(tx_valid1), (c == 2) ? 32'd0 : 32'd1);
                if (c != 2) chk("n1_data", 32'(tx_data1), 32'(d1[c]));
            end
            if (c == 7) begin
                chk("n1_done", 32'(done1), 32'd1);
                chk("n1_done_valid", 32'(tx_valid1), 32'd0);
            end
            if (c == 8) chk("n1_busy", 32'(busy1), 32'd0);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug-side reader for the register file's debug read port (`dbg_reg_ra` / `dbg_reg_rd`). On a start pulse it walks registers x0..x(NUM_REGS-1) and snapshots each one. It then streams each register as bytes over a valid/ready byte interface, which feeds the board's UART transmitter. This lets the host dump the architectural register state without halting the core's write port.

## Interface
Parameters:
- `NUM_REGS`, 32: number of registers dumped, starting at x0. Legal range 1..32.
- `HEADER`, 8'hA5: frame header byte sent before register data.

Ports:
- `clk`  in  1: single clock, all state changes on its rising edge.
- `rstn`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: request a dump. Sampled only in IDLE.
- `dbg_reg_ra`  out  5: register index driven to the register file's debug read address.
- `dbg_reg_rd`  in  32: combinational read data returned from the register file.
- `tx_data`  out  8: byte to transmit.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: consumer accepts the byte. A transfer occurs on an edge with `tx_valid && tx_ready`.
- `busy`  out  1: a dump is in progress (any state other than IDLE).
- `done`  out  1: one-cycle pulse when the dump completes.

## Operation
- States: IDLE, HEADER, LOAD, SEND, DONE. Internal registers:
  - `idx` (5 bits)
  - `byte_cnt` (2 bits)
  - `shreg` (32 bits)
- IDLE: with `start`=1, clear `idx` to 0 and go to HEADER. Otherwise remain in IDLE.
- HEADER: `tx_valid`=1, `tx_data`=HEADER. Go to LOAD on the transfer.
- LOAD (exactly 1 cycle): `dbg_reg_ra`=`idx` and `tx_valid`=0. Capture `dbg_reg_rd` into `shreg`, clear `byte_cnt`, then go to SEND.
- SEND: `tx_valid`=1, `tx_data`=`shreg[31:24]`, so the most significant byte goes out first. On each transfer:
  - Shift `shreg` left by 8 and increment `byte_cnt`.
  - On the transfer with `byte_cnt`=3 and `idx`=NUM_REGS-1, go to DONE.
  - On the transfer with `byte_cnt`=3 and any other `idx`, increment `idx` and go to LOAD.
- DONE (1 cycle): `done`=1, `tx_valid`=0. Then go to IDLE.
- The snapshot is taken in LOAD. Register-file writes that occur while that register's bytes are in flight do not alter the transmitted word.
- `dbg_reg_ra` is registered and holds `idx` in every state. It reads 0 in IDLE after reset.
- `start` outside IDLE is ignored. This includes the DONE cycle, and no request is queued.
- Frame length is 1 + 4*NUM_REGS bytes.

## Timing
- Reset values (asserted asynchronously, immediately on `rstn`=0):
  - `dbg_reg_ra`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0
  - state=IDLE, `idx`=0, `byte_cnt`=0, `shreg`=0
- Reset mid-dump aborts the dump: `tx_valid` drops with no further bytes, and no `done` pulse is issued. The next `start` begins a fresh frame with the header.
- Latency: `start` sampled at edge 0 puts HEADER on `tx_data`/`tx_valid` in cycle 1.
- With `tx_ready` held at 1:
  - Each register costs 5 cycles (1 LOAD + 4 SEND).
  - For NUM_REGS=32, `done` pulses in cycle 162, and `busy` is high for cycles 1..162.
- Handshake rules:
  - Once `tx_valid` is asserted, it stays high and `tx_data` stays stable until the transfer.
  - `tx_valid` does not depend combinationally on `tx_ready`.
- `busy` is 1 in HEADER/LOAD/SEND/DONE and falls the cycle after `done`.
- NUM_REGS=1 sends the header plus the 4 bytes of x0, then DONE.

## Test plan
- Reset: hold `rstn`=0 with random `start` and `tx_ready`. All outputs must be 0 and `busy`=0.
- Full dump: preload x_i = 32'h1000_0000+i (x0 reads 0) and hold `tx_ready`=1, then pulse `start`.
  - Stream must be A5, 00 00 00 00, 10 00 00 01, … , 10 00 00 1F (129 bytes).
  - `done` must pulse in cycle 162.
- Backpressure: repeat the full dump with `tx_ready` random at 30% duty.
  - The byte stream must be identical.
  - `tx_data` must be stable whenever `tx_valid`=1 and `tx_ready`=0.
- Snapshot: write x5=32'hDEAD_BEEF on the cycle after LOAD of `idx`=5 (old value 32'h1000_0005). The bytes 10 00 00 05 must be transmitted.
- Start filtering: pulse `start` during SEND and during DONE. Exactly one frame is produced and `busy` returns to 0.
- Abort: drop `rstn` while byte 2 of x7 is pending, then restart.
  - `tx_valid` must go to 0 immediately.
  - The next frame must begin with A5 followed by x0.
